// File: rtl/lz77_pkg.sv
// Shared LZ77 parameters, token layout and decoder state encoding.
// Imported by the decoder, its history buffer and the compressor's output packer.
package lz77_pkg;

  localparam int DATA_W         = 8;
  localparam int SEARCH_SIZE    = 8;
  localparam int LOOKAHEAD_SIZE = 6;
  localparam int OFF_W          = 4;
  localparam int LEN_W          = 3;
  localparam int MAX_LEN        = LOOKAHEAD_SIZE - 1;
  localparam int PTR_W          = $clog2(SEARCH_SIZE);
  localparam int FILL_W         = $clog2(SEARCH_SIZE + 1);

  typedef struct packed {
    logic [OFF_W-1:0]  offset;
    logic [LEN_W-1:0]  length;
    logic [DATA_W-1:0] lit_char;
    logic              last;
  } token_t;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_WAIT = 3'd1,
    ST_COPY = 3'd2,
    ST_LIT  = 3'd3,
    ST_DONE = 3'd4
  } state_e;

  function automatic logic [LEN_W-1:0] clamp_len(input logic [LEN_W-1:0] len);
    return (int'(len) > MAX_LEN) ? LEN_W'(MAX_LEN) : len;
  endfunction

endpackage

// File: rtl/lz77_history_buf.sv
// Circular history window: one write per emitted byte, combinational read
// at (write pointer - offset), fill count saturating at the window depth.
module lz77_history_buf
  import lz77_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              clear_i,
  input  logic              wr_en_i,
  input  logic [DATA_W-1:0] wr_data_i,
  input  logic [PTR_W-1:0]  rd_offset_i,
  output logic [DATA_W-1:0] rd_data_o,
  output logic [FILL_W-1:0] fill_o
);

  logic [DATA_W-1:0] mem_q [SEARCH_SIZE];
  logic [PTR_W-1:0]  ptr_q, ptr_d;
  logic [FILL_W-1:0] fill_q, fill_d;
  logic [PTR_W-1:0]  rd_addr;

  always_comb begin
    ptr_d  = ptr_q;
    fill_d = fill_q;
    if (clear_i) begin
      ptr_d  = '0;
      fill_d = '0;
    end else if (wr_en_i) begin
      ptr_d = ptr_q + 1'b1;
      if (int'(fill_q) < SEARCH_SIZE) fill_d = fill_q + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      ptr_q  <= '0;
      fill_q <= '0;
    end else begin
      ptr_q  <= ptr_d;
      fill_q <= fill_d;
    end
  end

  // NOTE: the storage array has no reset; fill_q already marks which entries are meaningful.
  always_ff @(posedge clk) begin
    if (wr_en_i) mem_q[ptr_q] <= wr_data_i;
  end

  assign rd_addr   = ptr_q - rd_offset_i;
  assign rd_data_o = mem_q[rd_addr];
  assign fill_o    = fill_q;

endmodule

// File: rtl/lz77_decoder.sv
// Streaming LZ77 decoder: turns (offset, length, char, last) tokens back into
// a byte stream, one byte per accepted output cycle.
module lz77_decoder
  import lz77_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              tok_valid,
  output logic              tok_ready,
  input  logic [OFF_W-1:0]  tok_offset,
  input  logic [LEN_W-1:0]  tok_length,
  input  logic [DATA_W-1:0] tok_char,
  input  logic              tok_last,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              done,
  output logic              err
);

  state_e            state_q, state_d;
  token_t            tok_q, tok_d;
  logic              err_q, err_d;
  logic              hist_clr, hist_wr;
  logic [DATA_W-1:0] hist_rd;
  logic [FILL_W-1:0] fill;
  logic              off_range, off_bad, tok_illegal;

  lz77_history_buf u_hist (
    .clk         (clk),
    .rst_n       (rst_n),
    .clear_i     (hist_clr),
    .wr_en_i     (hist_wr),
    .wr_data_i   (out_data),
    .rd_offset_i (tok_q.offset[PTR_W-1:0]),
    .rd_data_o   (hist_rd),
    .fill_o      (fill)
  );

  always_comb begin
    off_range   = (int'(tok_offset) > int'(fill)) || (int'(tok_offset) > SEARCH_SIZE);
    off_bad     = (tok_offset == '0) || off_range;
    tok_illegal = off_range || ((tok_offset == '0) && (tok_length != '0))
                  || (int'(tok_length) > MAX_LEN);
  end

  // NOTE: every output and next-state signal gets a default first so no path infers a latch.
  always_comb begin
    state_d   = state_q;
    tok_d     = tok_q;
    err_d     = err_q;
    tok_ready = 1'b0;
    out_valid = 1'b0;
    out_data  = '0;
    done      = 1'b0;
    hist_clr  = 1'b0;
    hist_wr   = 1'b0;
    unique case (state_q)
      ST_IDLE, ST_DONE: begin
        done = (state_q == ST_DONE);
        if (start) begin
          state_d  = ST_WAIT;
          hist_clr = 1'b1;
          err_d    = 1'b0;
        end
      end
      ST_WAIT: begin
        tok_ready = 1'b1;
        if (tok_valid) begin
          // An unusable offset is stored as 0, which the copy path reads as "emit zeros".
          tok_d.offset   = off_bad ? '0 : tok_offset;
          tok_d.length   = clamp_len(tok_length);
          tok_d.lit_char = tok_char;
          tok_d.last     = tok_last;
          err_d          = err_q | tok_illegal;
          state_d        = (tok_length != '0) ? ST_COPY : ST_LIT;
        end
      end
      ST_COPY: begin
        out_valid = 1'b1;
        out_data  = (tok_q.offset == '0) ? '0 : hist_rd;
        if (out_ready) begin
          hist_wr      = 1'b1;
          tok_d.length = tok_q.length - 1'b1;
          if (tok_q.length == LEN_W'(1)) state_d = ST_LIT;
        end
      end
      ST_LIT: begin
        out_valid = 1'b1;
        out_data  = tok_q.lit_char;
        if (out_ready) begin
          hist_wr = 1'b1;
          state_d = tok_q.last ? ST_DONE : ST_WAIT;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // The token's length field doubles as the remaining-copy counter.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      tok_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      tok_q   <= tok_d;
      err_q   <= err_d;
    end
  end

  assign err = err_q;

endmodule

// File: tb/tb_lz77_decoder.sv
// Directed and randomized checks of lz77_decoder against a stream-level model
// that resolves each copy directly from the full decoded byte history.
module tb_lz77_decoder;
  import lz77_pkg::*;

  logic              clk;
  logic              rst_n;
  logic              start;
  logic              tok_valid;
  logic              tok_ready;
  logic [OFF_W-1:0]  tok_offset;
  logic [LEN_W-1:0]  tok_length;
  logic [DATA_W-1:0] tok_char;
  logic              tok_last;
  logic              out_valid;
  logic [DATA_W-1:0] out_data;
  logic              out_ready;
  logic              done;
  logic              err;

  int checks   = 0;
  int failures = 0;

  logic [7:0] stream[$];
  logic [7:0] exp_q[$];
  bit         model_err;

  lz77_decoder dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .start      (start),
    .tok_valid  (tok_valid),
    .tok_ready  (tok_ready),
    .tok_offset (tok_offset),
    .tok_length (tok_length),
    .tok_char   (tok_char),
    .tok_last   (tok_last),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .out_ready  (out_ready),
    .done       (done),
    .err        (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog expired before the bench completed");
    $fatal(1, "watchdog");
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  function automatic int model_fill();
    return (stream.size() < SEARCH_SIZE) ? stream.size() : SEARCH_SIZE;
  endfunction

  // Decoded stream since start: a copy byte is stream[n - offset], or 0 if that offset is unusable.
  task automatic model_token(input int off, input int len, input logic [7:0] ch);
    int fillm;
    int l;
    bit bad_off;
    logic [7:0] b;
    fillm   = model_fill();
    bad_off = (off == 0) || (off > fillm) || (off > SEARCH_SIZE);
    if ((off > fillm) || (off > SEARCH_SIZE) || (off == 0 && len > 0) || (len > MAX_LEN))
      model_err = 1'b1;
    l = (len > MAX_LEN) ? MAX_LEN : len;
    for (int i = 0; i < l; i++) begin
      if (bad_off) b = 8'h00;
      else         b = stream[stream.size() - off];
      stream.push_back(b);
      exp_q.push_back(b);
    end
    stream.push_back(ch);
    exp_q.push_back(ch);
  endtask

  task automatic do_start();
    start = 1'b1;
    step();
    start = 1'b0;
    stream.delete();
    exp_q.delete();
    model_err = 1'b0;
    check("start_tok_ready", tok_ready, 1);
    check("start_err_clear", err, 0);
    check("start_done_clear", done, 0);
  endtask

  task automatic send_token(input int off, input int len, input logic [7:0] ch, input bit last);
    int guard;
    model_token(off, len, ch);
    tok_offset = OFF_W'(off);
    tok_length = LEN_W'(len);
    tok_char   = ch;
    tok_last   = last;
    tok_valid  = 1'b1;
    guard = 0;
    while (tok_ready !== 1'b1 && guard < 10) begin
      step();
      guard++;
    end
    check("tok_ready_wait", tok_ready, 1);
    step();
    tok_valid = 1'b0;
    check("first_byte_latency", out_valid, 1);
    check("err_on_accept", err, model_err);
  endtask

  task automatic drain(input int stall, input int hold_from, input int hold_cnt, input bit last);
    int cyc;
    bit stalled;
    logic [7:0] held;
    cyc = 0;
    stalled = 1'b0;
    held = '0;
    while (exp_q.size() > 0 && cyc < 300) begin
      if (cyc >= hold_from && cyc < hold_from + hold_cnt) out_ready = 1'b0;
      else out_ready = ($urandom_range(99, 0) >= stall);
      if (stalled) begin
        check("bp_valid_hold", out_valid, 1);
        check("bp_data_hold", out_data, held);
      end
      if (stall == 0 && hold_cnt == 0) check("no_gap", out_valid, 1);
      stalled = 1'b0;
      if (out_valid === 1'b1) begin
        if (out_ready) check("out_data", out_data, exp_q.pop_front());
        else begin
          stalled = 1'b1;
          held = out_data;
        end
      end
      step();
      cyc++;
    end
    check("bytes_left", exp_q.size(), 0);
    out_ready = 1'b1;
    if (last) begin
      check("done_set", done, 1);
      check("done_tok_ready", tok_ready, 0);
      check("done_out_valid", out_valid, 0);
    end else begin
      check("wait_tok_ready", tok_ready, 1);
    end
    check("err_after_token", err, model_err);
  endtask

  task automatic run_token(input int off, input int len, input logic [7:0] ch, input bit last,
                           input int stall, input int hold_from, input int hold_cnt);
    send_token(off, len, ch, last);
    drain(stall, hold_from, hold_cnt, last);
  endtask

  initial begin
    int ntok;
    int len;
    int off;
    int fillm;
    int stall;
    bit last;
    rst_n      = 1'b0;
    start      = 1'b0;
    tok_valid  = 1'b0;
    tok_offset = '0;
    tok_length = '0;
    tok_char   = '0;
    tok_last   = 1'b0;
    out_ready  = 1'b1;
    model_err  = 1'b0;
    step();
    step();
    check("rst_tok_ready", tok_ready, 0);
    check("rst_out_valid", out_valid, 0);
    check("rst_out_data", out_data, 0);
    check("rst_done", done, 0);
    check("rst_err", err, 0);
    rst_n = 1'b1;
    step();
    check("idle_tok_ready", tok_ready, 0);

    // Literals only
    do_start();
    run_token(0, 0, "A", 1'b0, 0, 0, 0);
    run_token(0, 0, "B", 1'b1, 0, 0, 0);

    // Overlapping copy: ABABABC
    do_start();
    run_token(0, 0, "A", 1'b0, 0, 0, 0);
    run_token(0, 0, "B", 1'b0, 0, 0, 0);
    run_token(2, 4, "C", 1'b1, 0, 0, 0);
    check("overlap_len", stream.size(), 7);

    // Wrap-around of the write pointer
    do_start();
    for (int i = 0; i < 10; i++) run_token(0, 0, 8'(48 + i), 1'b0, 0, 0, 0);
    run_token(8, 3, "X", 1'b1, 0, 0, 0);

    // Backpressure: three stalled cycles mid-copy
    do_start();
    run_token(0, 0, "Y", 1'b0, 0, 0, 0);
    run_token(1, 5, "Z", 1'b1, 0, 2, 3);
    check("bp_total_bytes", stream.size(), 7);

    // Illegal offset: two zero bytes, literal, err sticky until start
    do_start();
    run_token(0, 0, "a", 1'b0, 0, 0, 0);
    run_token(0, 0, "b", 1'b0, 0, 0, 0);
    run_token(5, 2, "Q", 1'b0, 0, 0, 0);
    check("err_set", err, 1);
    run_token(0, 0, "R", 1'b1, 0, 0, 0);
    check("err_sticky", err, 1);
    do_start();
    run_token(0, 7, "L", 1'b1, 0, 0, 0);
    check("err_len_clamp", err, 1);

    // Reset in the middle of a copy
    do_start();
    run_token(0, 0, "p", 1'b0, 0, 0, 0);
    send_token(1, 5, "q", 1'b0);
    step();
    step();
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    exp_q.delete();
    check("midrst_out_valid", out_valid, 0);
    check("midrst_tok_ready", tok_ready, 0);
    check("midrst_out_data", out_data, 0);
    check("midrst_err", err, 0);
    step();
    check("midrst_idle", tok_ready, 0);
    do_start();
    run_token(0, 0, "K", 1'b1, 0, 0, 0);

    // Randomized streams against the model
    for (int s = 0; s < 12; s++) begin
      ntok  = $urandom_range(14, 2);
      stall = (s % 3 == 0) ? 0 : $urandom_range(60, 10);
      do_start();
      for (int k = 0; k < ntok; k++) begin
        fillm = model_fill();
        last  = (k == ntok - 1);
        len   = ($urandom_range(3, 0) == 0) ? 0 : $urandom_range(7, 1);
        if (len == 0) off = 0;
        else if (fillm > 0 && $urandom_range(9, 0) < 8) off = $urandom_range(fillm, 1);
        else off = $urandom_range(15, 0);
        run_token(off, len, 8'($urandom_range(255, 0)), last, stall, 0, 0);
      end
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
